// File: rtl/mips_mem_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DONE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/arb_prio_sel.sv
// Grant selection for the shared memory port: data first, unless fetch has
// waited through STARVE_LIMIT consecutive data grants.
module arb_prio_sel #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic if_req,
  input  logic d_req,
  output logic gnt_d,
  output logic gnt_if
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve;
  logic          starved;

  assign starved = (starve >= CW'(STARVE_LIMIT));

  always_comb begin
    gnt_d  = arb_en && d_req && !(starved && if_req);
    gnt_if = arb_en && if_req && !gnt_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve <= '0;
    end else if (gnt_d) begin
      if (!if_req)
        starve <= '0;
      else if (!starved)
        starve <= starve + CW'(1);
    end else if (gnt_if) begin
      starve <= '0;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a byte-wide big-endian array between fetch and data ports; every
// word access runs as four byte beats followed by a one-cycle done pulse.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);
  localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_WORD - 1);

  arb_state_t        state;
  arb_owner_t        owner;
  logic              we_q;
  logic [1:0]        beat;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata_q;
  logic [31:0]       word;
  logic [31:0]       load_word;
  logic [31:0]       sel_addr;
  logic              gnt_d, gnt_if;
  logic              unused_addr_bits;

  // Beat 0 is the most significant byte of the word.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    byte_of = w[31:24];
      2'd1:    byte_of = w[23:16];
      2'd2:    byte_of = w[15:8];
      default: byte_of = w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    put_byte = w;
    case (k)
      2'd0:    put_byte[31:24] = b;
      2'd1:    put_byte[23:16] = b;
      2'd2:    put_byte[15:8]  = b;
      default: put_byte[7:0]   = b;
    endcase
  endfunction

  arb_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk    (clk),
    .reset  (reset),
    .arb_en (state == IDLE),
    .if_req (if_req),
    .d_req  (d_req),
    .gnt_d  (gnt_d),
    .gnt_if (gnt_if)
  );

  assign sel_addr         = gnt_d ? d_addr : if_addr;
  assign unused_addr_bits = ^{sel_addr[31:ADDR_W], sel_addr[1:0]};
  assign load_word        = {word[31:8], mem_rdata};

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state == XFER) begin
      mem_addr = base + ADDR_W'(beat);
      mem_we   = we_q;
      if (we_q)
        mem_wdata = byte_of(wdata_q, beat);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      we_q     <= 1'b0;
      beat     <= '0;
      busy     <= 1'b0;
      if_done  <= 1'b0;
      d_done   <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: if (gnt_d || gnt_if) begin
          state <= XFER;
          owner <= gnt_d ? OWN_D : OWN_IF;
          we_q  <= gnt_d && d_we;
          beat  <= '0;
          busy  <= 1'b1;
        end
        XFER: begin
          beat <= beat + 2'd1;
          if (beat == LAST_BEAT) begin
            state <= DONE;
            if (owner == OWN_D) d_done <= 1'b1;
            else                if_done <= 1'b1;
            // Stores leave the read-back register untouched.
            if (!we_q) begin
              if (owner == OWN_D) d_rdata  <= load_word;
              else                if_rdata <= load_word;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && (gnt_d || gnt_if)) begin
      base    <= {sel_addr[ADDR_W-1:2], 2'b00};
      wdata_q <= d_wdata;
    end
    if (state == XFER && !we_q)
      word <= put_byte(word, beat, mem_rdata);
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-array memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  logic [7:0]  mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_a = '0;
  logic [7:0]  pl_d = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_a] <= pl_d;
  end
  assign mem_rdata = mem[mem_addr];

  mem_port_arbiter #(.ADDR_W(10), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [9:0]  exp_first;
    logic [9:0]  exp_last;
    int          exp_we;
    int          chk_a;
    logic [31:0] chk_w;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdw(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic poke(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pl_en = 1'b1;
      pl_a  = 10'(a + i);
      pl_d  = w[31-8*i -: 8];
      @(posedge clk);
      #1 pl_en = 1'b0;
    end
  endtask

  task automatic d_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output int wecnt, output logic [9:0] af,
                        output logic [9:0] al, output int ifd);
    @(negedge clk);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    lat = 0; wecnt = 0; af = '0; al = '0; ifd = 0;
    for (int n = 1; n <= 50; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (mem_we) wecnt++;
      if (n == 1) af = mem_addr;
      if (n == 4) al = mem_addr;
      if (if_done) ifd++;
      if (d_done) begin
        lat = n;
        break;
      end
    end
    d_req = 1'b0;
  endtask

  initial begin
    int lat, wecnt, ifd, dcyc, icyc, both, nev;
    logic [9:0] af, al;
    logic [9:0] seq;

    vt[0] = '{1'b0, 32'h0000_0004, 32'h0,          32'h0000_0028, 10'h004, 10'h007, 0, 4,     32'h0000_0028};
    vt[1] = '{1'b1, 32'h0000_0008, 32'h0000_0001,  32'h0000_0028, 10'h008, 10'h00B, 4, 8,     32'h0000_0001};
    vt[2] = '{1'b0, 32'h0000_0006, 32'h0,          32'h0000_0028, 10'h004, 10'h007, 0, 4,     32'h0000_0028};
    vt[3] = '{1'b0, 32'h0000_03FE, 32'h0,          32'h1122_3344, 10'h3FC, 10'h3FF, 0, 'h3FC, 32'h1122_3344};
    vt[4] = '{1'b0, 32'hFFFF_F40B, 32'h0,          32'h0000_0001, 10'h008, 10'h00B, 0, 8,     32'h0000_0001};
    vt[5] = '{1'b1, 32'h0000_03FD, 32'hDEAD_BEEF,  32'h0000_0001, 10'h3FC, 10'h3FF, 4, 'h3FC, 32'hDEAD_BEEF};
    vt[6] = '{1'b0, 32'h0000_03FC, 32'h0,          32'hDEAD_BEEF, 10'h3FC, 10'h3FF, 0, 'h3FC, 32'hDEAD_BEEF};

    // Preload while the arbiter is held in reset.
    poke(0, 32'h0C00_0005);
    poke(4, 32'h0000_0028);
    poke(8, 32'hFFFF_FFFF);
    poke('h3FC, 32'h1122_3344);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_dones", {30'd0, d_done, if_done}, 0);
    chk("rst_rdata", d_rdata | if_rdata, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      d_xfer(vt[i].we, vt[i].addr, vt[i].wdata, lat, wecnt, af, al, ifd);
      chk($sformatf("v%0d_latency", i), 32'(lat), 5);
      chk($sformatf("v%0d_d_rdata", i), d_rdata, vt[i].exp_rd);
      chk($sformatf("v%0d_we_cycles", i), 32'(wecnt), 32'(vt[i].exp_we));
      chk($sformatf("v%0d_first_addr", i), 32'(af), 32'(vt[i].exp_first));
      chk($sformatf("v%0d_last_addr", i), 32'(al), 32'(vt[i].exp_last));
      chk($sformatf("v%0d_if_done", i), 32'(ifd), 0);
      chk($sformatf("v%0d_mem_word", i), rdw(vt[i].chk_a), vt[i].chk_w);
      @(negedge clk);
    end

    // Simultaneous requests: data first, fetch in the next slot.
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h4; if_addr = 32'h0; d_req = 1'b1; if_req = 1'b1;
    dcyc = 0; icyc = 0; both = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (d_done && if_done) both++;
      if (d_done) begin dcyc = n; d_req = 1'b0; end
      if (if_done) begin icyc = n; if_req = 1'b0; end
      if (dcyc != 0 && icyc != 0) break;
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("sim_d_cycle", 32'(dcyc), 5);
    chk("sim_if_cycle", 32'(icyc), 11);
    chk("sim_if_rdata", if_rdata, 32'h0C00_0005);
    chk("sim_d_rdata", d_rdata, 32'h0000_0028);
    chk("sim_both_done", 32'(both), 0);

    // Starvation guard: four data grants, then fetch, then counting restarts.
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h8; if_addr = 32'h3FC; d_req = 1'b1; if_req = 1'b1;
    seq = '0; nev = 0; both = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (d_done && if_done) both++;
      if (d_done || if_done) begin
        seq = {seq[8:0], d_done};
        nev++;
      end
      if (nev == 10) break;
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("starve_events", 32'(nev), 10);
    chk("starve_order", 32'(seq), 32'(10'b1111011110));
    chk("starve_if_rdata", if_rdata, 32'hDEAD_BEEF);
    chk("starve_both_done", 32'(both), 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a store: two bytes land, the rest do not.
    @(negedge clk);
    d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hAABB_CCDD; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre_we", 32'(mem_we), 1);
    reset = 1'b0;
    #1;
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_d_rdata", d_rdata, 0);
    d_req = 1'b0; d_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_mem_word", rdw(8), 32'hAABB_0001);
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 0);
    chk("abort_idle_dones", {30'd0, d_done, if_done}, 0);

    d_xfer(1'b0, 32'h8, 32'h0, lat, wecnt, af, al, ifd);
    chk("recover_latency", 32'(lat), 5);
    chk("recover_d_rdata", d_rdata, 32'hAABB_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
